// File: rtl/vx_mat_feeder.sv
// vx_mat_feeder
// Pops packed entries from the matrix buffer, holds each one, and streams its
// words in index order over a valid/ready port. Each entry can be replayed for
// operand reuse. The next entry is popped on the final transfer of the current
// one, so back-to-back entries stream without a bubble.
module vx_mat_feeder #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 4,
    parameter int REP_W    = 4,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_flush,
    input  logic                      i_buf_empty,
    input  logic [NUM_REGS*WIDTH-1:0] i_buf_data,
    output logic                      o_buf_read,
    input  logic [REP_W-1:0]          i_repeat,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [WIDTH-1:0]          o_data,
    output logic [IDX_W-1:0]          o_reg_idx,
    output logic                      o_last,
    output logic                      o_busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [NUM_REGS*WIDTH-1:0] hold_q, hold_d;
    logic [REP_W-1:0]          rep_total_q, rep_total_d;
    logic [REP_W-1:0]          pass_cnt_q, pass_cnt_d;
    logic [IDX_W-1:0]          reg_idx_q, reg_idx_d;

    logic             xfer;
    logic             wordIsLast;
    logic             passIsFinal;
    logic             popEn;
    logic [WIDTH-1:0] curWord;

    // Handshake and end-of-entry conditions; a pop happens from IDLE or on the final transfer, never under reset/flush or with an empty buffer
    always_comb begin
        xfer        = o_valid & i_ready;
        wordIsLast  = (reg_idx_q == IDX_W'(NUM_REGS - 1));
        passIsFinal = (pass_cnt_q == rep_total_q);
        popEn       = !i_buf_empty && !i_rst && !i_flush &&
                      ((state_q == IDLE) || (xfer && o_last));
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush wins over everything; leave STREAM only when the final word goes out with nothing to pop
    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (popEn) begin
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    if (xfer && o_last && !popEn) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Select the held word addressed by the current index
    always_comb begin
        curWord = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (reg_idx_q == IDX_W'(k)) begin
                curWord = hold_q[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output logic: data comes from the hold registers only and is forced to zero when idle
    always_comb begin
        o_valid    = (state_q == STREAM);
        o_busy     = (state_q != IDLE);
        o_last     = (state_q == STREAM) && wordIsLast && passIsFinal;
        o_data     = (state_q == STREAM) ? curWord : '0;
        o_reg_idx  = reg_idx_q;
        o_buf_read = popEn;
    end

    // Datapath next-state: load on pop, advance index/pass on each transfer, clear counters on flush
    always_comb begin
        hold_d      = hold_q;
        rep_total_d = rep_total_q;
        pass_cnt_d  = pass_cnt_q;
        reg_idx_d   = reg_idx_q;
        if (i_flush) begin
            reg_idx_d  = '0;
            pass_cnt_d = '0;
        end else if (popEn) begin
            hold_d      = i_buf_data;
            rep_total_d = i_repeat;
            reg_idx_d   = '0;
            pass_cnt_d  = '0;
        end else if (xfer) begin
            if (!wordIsLast) begin
                reg_idx_d = reg_idx_q + IDX_W'(1);
            end else begin
                reg_idx_d = '0;
                if (!passIsFinal) begin
                    pass_cnt_d = pass_cnt_q + REP_W'(1);
                end else begin
                    pass_cnt_d = '0;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_q      <= '0;
            rep_total_q <= '0;
            pass_cnt_q  <= '0;
            reg_idx_q   <= '0;
        end else begin
            hold_q      <= hold_d;
            rep_total_q <= rep_total_d;
            pass_cnt_q  <= pass_cnt_d;
            reg_idx_q   <= reg_idx_d;
        end
    end

endmodule
